// File: rtl/logic_combine_pipe.sv
// N-channel bitwise combiner (AND/OR/XOR/NAND) feeding a stallable valid/ready pipeline.
// Optional output toggle counter enabled by defining LOGIC_COMBINE_PIPE_TOGGLE_CNT_EN.
module logic_combine_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              op,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    busy,
    output logic [15:0]             toggle_cnt
);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    logic [WIDTH-1:0]  and_red;
    logic [WIDTH-1:0]  or_red;
    logic [WIDTH-1:0]  xor_red;
    logic [WIDTH-1:0]  combined;

    logic [STAGES-1:0] stage_valid;
    logic [WIDTH-1:0]  stage_data [STAGES];
    logic [STAGES-1:0] src_valid;
    logic [WIDTH-1:0]  src_data [STAGES];
    logic [STAGES-1:0] advance;
    logic              hole;

    // NAND inverts the full AND-reduction rather than chaining pairwise NANDs
    always_comb begin
        and_red  = '1;
        or_red   = '0;
        xor_red  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            and_red = and_red & in_data[k*WIDTH +: WIDTH];
            or_red  = or_red  | in_data[k*WIDTH +: WIDTH];
            xor_red = xor_red ^ in_data[k*WIDTH +: WIDTH];
        end
        case (op_t'(op))
            OP_AND:  combined = and_red;
            OP_OR:   combined = or_red;
            OP_XOR:  combined = xor_red;
            default: combined = ~and_red;
        endcase
    end

    // A stage may advance if any stage at or downstream of it is empty, or the consumer takes the head
    always_comb begin
        advance = '0;
        hole    = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            hole       = hole || !stage_valid[i];
            advance[i] = hole;
        end
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : gen_stage
            if (g == 0) begin : gen_head
                assign src_valid[g] = in_valid;
                assign src_data[g]  = combined;
            end else begin : gen_body
                assign src_valid[g] = stage_valid[g-1];
                assign src_data[g]  = stage_data[g-1];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_valid[g] <= 1'b0;
                    stage_data[g]  <= '0;
                end else if (advance[g]) begin
                    stage_valid[g] <= src_valid[g];
                    if (src_valid[g]) begin
                        stage_data[g] <= src_data[g];
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = advance[0];
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[STAGES-1];
    assign busy      = |stage_valid;

`ifdef LOGIC_COMBINE_PIPE_TOGGLE_CNT_EN
    logic [WIDTH-1:0] prev_result;
    logic [15:0]      cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_result <= '0;
            cnt         <= '0;
        end else if (out_valid && out_ready) begin
            prev_result <= out_data;
            if (out_data != prev_result && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    assign toggle_cnt = cnt;
`else
    assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_logic_combine_pipe.sv
// Directed self-checking bench for logic_combine_pipe at default parameters (8-bit, 2 channels, 2 stages).
module tb_logic_combine_pipe;

    localparam int WIDTH  = 8;
    localparam int NUM_IN = 2;
    localparam int STAGES = 2;

    logic                    clk;
    logic                    rst_n;
    logic [1:0]              op;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    busy;
    logic [15:0]             toggle_cnt;

    int check_count;
    int pass_count;

    logic [7:0] rand_a [100];
    logic [7:0] rand_b [100];
    logic [1:0] rand_op [100];

    logic [7:0] op_exp [4];
    logic [7:0] tog_vals [5];
    logic [15:0] tog_exp;

    logic_combine_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .STAGES(STAGES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .toggle_cnt (toggle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        in_valid = valid;
        op       = o;
        in_data  = {b, a};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst_n       = 1'b0;
        out_ready   = 1'b1;
        applyStimulus(1'b0, 2'b00, 8'h00, 8'h00);

        // Reset held for three edges, then released
        repeat (3) step();
        rst_n = 1'b1;
        step();
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", {24'd0, out_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_toggle_cnt", {16'd0, toggle_cnt}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // One beat per op on channels F0 / 3C, with hand-computed results
        op_exp[0] = 8'h30;
        op_exp[1] = 8'hFC;
        op_exp[2] = 8'hCC;
        op_exp[3] = 8'hCF;
        for (int o = 0; o < 4; o++) begin
            applyStimulus(1'b1, o[1:0], 8'hF0, 8'h3C);
            step();
            in_valid = 1'b0;
            checkOutput($sformatf("op%0d_not_yet", o), {31'd0, out_valid}, 32'd0);
            step();
            checkOutput($sformatf("op%0d_valid", o), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("op%0d_data", o), {24'd0, out_data}, {24'd0, op_exp[o]});
        end
        step();
        checkOutput("ops_drained", {31'd0, busy}, 32'd0);

        // Backpressure: only two beats fit, head stays stable, then all four drain back to back
        out_ready = 1'b0;
        applyStimulus(1'b1, 2'b10, 8'hF0, 8'h3C);
        checkOutput("bp_rdy0", {31'd0, in_ready}, 32'd1);
        step();
        applyStimulus(1'b1, 2'b00, 8'hFF, 8'h0F);
        checkOutput("bp_rdy1", {31'd0, in_ready}, 32'd1);
        step();
        applyStimulus(1'b1, 2'b01, 8'h12, 8'h34);
        checkOutput("bp_full_rdy", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_full_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_full_data", {24'd0, out_data}, 32'h0000_00CC);
        step();
        step();
        checkOutput("bp_stall_rdy", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_stall_data", {24'd0, out_data}, 32'h0000_00CC);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        step();
        applyStimulus(1'b1, 2'b11, 8'hAA, 8'h55);
        checkOutput("bp_beat1_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_beat1_data", {24'd0, out_data}, 32'h0000_000F);
        checkOutput("bp_beat3_rdy", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        checkOutput("bp_beat2_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_beat2_data", {24'd0, out_data}, 32'h0000_0036);
        step();
        checkOutput("bp_beat3_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_beat3_data", {24'd0, out_data}, 32'h0000_00FF);
        step();
        checkOutput("bp_empty_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_empty_hold", {24'd0, out_data}, 32'h0000_00FF);

        // Full throughput: 100 back-to-back beats, each result two cycles behind its input
        for (int i = 0; i < 100; i++) begin
            rand_a[i]  = 8'($urandom);
            rand_b[i]  = 8'($urandom);
            rand_op[i] = 2'($urandom_range(0, 3));
        end
        for (int t = 0; t < 102; t++) begin
            if (t >= 2) begin
                checkOutput($sformatf("tp_valid_%0d", t - 2), {31'd0, out_valid}, 32'd1);
                checkOutput($sformatf("tp_data_%0d", t - 2), {24'd0, out_data},
                            {24'd0, ref_model(rand_op[t-2], rand_a[t-2], rand_b[t-2])});
            end
            if (t < 100) begin
                applyStimulus(1'b1, rand_op[t], rand_a[t], rand_b[t]);
                checkOutput($sformatf("tp_rdy_%0d", t), {31'd0, in_ready}, 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        checkOutput("tp_done_valid", {31'd0, out_valid}, 32'd0);

        // Mid-stream reset discards both in-flight beats
        applyStimulus(1'b1, 2'b01, 8'h11, 8'h22);
        step();
        applyStimulus(1'b1, 2'b01, 8'h44, 8'h88);
        step();
        in_valid = 1'b0;
        checkOutput("mr_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        checkOutput("mr_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mr_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            checkOutput($sformatf("mr_no_stale_%0d", t), {31'd0, out_valid}, 32'd0);
        end

        // Toggle counter over results 00, 00, 5A, 5A, A5 after a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        tog_vals[0] = 8'h00;
        tog_vals[1] = 8'h00;
        tog_vals[2] = 8'h5A;
        tog_vals[3] = 8'h5A;
        tog_vals[4] = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'b00, tog_vals[i], 8'hFF);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
`ifdef LOGIC_COMBINE_PIPE_TOGGLE_CNT_EN
        tog_exp = 16'd2;
`else
        tog_exp = 16'd0;
`endif
        checkOutput("toggle_cnt", {16'd0, toggle_cnt}, {16'd0, tog_exp});
        checkOutput("toggle_last_data", {24'd0, out_data}, 32'h0000_00A5);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
